ram_port_arbiter: RTL and testbench

- Shares one single-port synchronous RAM (tri-state data bus, cs/we/oe control) between NUM_REQ requesters.
- Round-robin arbitration with a per-requester valid/ready request handshake.
- Sequences the RAM control pins for write and two-cycle read, and returns read data with a per-requester response strobe.
- Sits between client blocks and the RAM macro; it is the only driver of the RAM pins.

---
 rtl/ram_ctrl_pkg.sv | 16 +
 rtl/ram_rr_arbiter.sv | 39 +++
 rtl/ram_port_arbiter.sv | 117 +++++++++++
 tb/tb_ram_port_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_ctrl_pkg.sv
// ram_ctrl_pkg: shared FSM state encoding and id-width helper for the RAM port arbiter
package ram_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        RD_ADDR = 2'd2,
        RD_DATA = 2'd3
    } state_t;

    // A single requester still needs a 1-bit id field.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ram_rr_arbiter.sv
// ram_rr_arbiter: combinational round-robin grant, searching upward from ptr_i with wrap
//   req_i  request vector, one bit per requester
//   ptr_i  highest-priority requester index
//   en_i   grants are forced to zero when low
//   gnt_o  one-hot grant
//   id_o   binary index of the granted requester
module ram_rr_arbiter
    import ram_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]    id_o
);

    logic found;

    // Pass 0 scans indices at or above the pointer, pass 1 the wrapped-around
    // indices below it; the first hit in that order wins.
    always_comb begin
        gnt_o = '0;
        id_o  = '0;
        found = 1'b0;
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (en_i && !found && req_i[k] && ((p == 0) == (k >= int'(ptr_i)))) begin
                    gnt_o[k] = 1'b1;
                    id_o     = ID_W'(k);
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one single-port synchronous RAM between NUM_REQ requesters
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/req_ready      per-requester handshake, req_ready is a one-hot grant
//   req_we/req_addr/req_wdata per-requester command, packed by requester index
//   rsp_valid/rsp_rdata      one-cycle read-completion strobe and shared read data
//   ram_cs/ram_we/ram_oe     RAM control pins
//   ram_addr/ram_data        RAM address and bidirectional data bus
module ram_port_arbiter
    import ram_ctrl_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          ram_cs,
    output logic                          ram_we,
    output logic                          ram_oe,
    output logic [ADDR_WIDTH-1:0]         ram_addr,
    inout  wire  [DATA_WIDTH-1:0]         ram_data
);

    localparam int ID_W = id_width(NUM_REQ);

    state_t                state_q, state_d;
    logic [ID_W-1:0]       ptr_q, ptr_d, id_q, id_d, win;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic [NUM_REQ-1:0]    rsp_q, rsp_d;

    // Grants are suppressed while rst is held so req_ready reads 0 in reset.
    ram_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req_i (req_valid),
        .ptr_i (ptr_q),
        .en_i  (state_q == IDLE && !rst),
        .gnt_o (req_ready),
        .id_o  (win)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            rsp_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            rsp_q   <= rsp_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        rsp_d   = '0;
        case (state_q)
            IDLE: begin
                if (|req_ready) begin
                    id_d    = win;
                    we_d    = req_we[win];
                    addr_d  = req_addr[win*ADDR_WIDTH +: ADDR_WIDTH];
                    wdata_d = req_wdata[win*DATA_WIDTH +: DATA_WIDTH];
                    ptr_d   = (win == ID_W'(NUM_REQ-1)) ? '0 : win + ID_W'(1);
                    state_d = req_we[win] ? WRITE : RD_ADDR;
                end
            end
            WRITE:   state_d = IDLE;
            RD_ADDR: state_d = RD_DATA;
            default: begin
                // The RAM drives the word registered during RD_ADDR while oe is high.
                rsp_d   = NUM_REQ'(1) << id_q;
                rdata_d = ram_data;
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        ram_cs    = state_q != IDLE;
        ram_we    = state_q == WRITE;
        ram_oe    = state_q == RD_DATA;
        ram_addr  = addr_q;
        rsp_valid = rsp_q;
        rsp_rdata = rdata_q;
    end

    // Only WRITE drives the bus; IDLE always sits between RD_DATA and WRITE.
    assign ram_data = (state_q == WRITE) ? wdata_q : 'z;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: scoreboard bench with a latency/round-robin reference model and a RAM model
module tb_ram_port_arbiter;

    localparam int N  = 3;
    localparam int AW = 4;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    req_we = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            ram_cs, ram_we, ram_oe;
    logic [AW-1:0]   ram_addr;
    wire  [DW-1:0]   ram_data;

    ram_port_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .ram_cs    (ram_cs),
        .ram_we    (ram_we),
        .ram_oe    (ram_oe),
        .ram_addr  (ram_addr),
        .ram_data  (ram_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Single-port synchronous RAM: read word registered when cs & !we, driven while oe.
    logic [DW-1:0] ram [16];
    logic [DW-1:0] rd_q = '0;
    always @(posedge clk) begin
        if (ram_cs && ram_we) ram[ram_addr] <= ram_data;
        if (ram_cs && !ram_we) rd_q <= ram[ram_addr];
    end
    assign ram_data = ram_oe ? rd_q : 'z;

    typedef struct {
        int            id;
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    exp_t          exp_q[$];
    int            glog[$];
    logic [DW-1:0] mem_m [16];
    int            ptr_m = 0;
    int            acc_c = -10;
    int            free_c = 0;
    bit            cur_we;
    logic [AW-1:0] cur_addr;
    logic [DW-1:0] cur_wdata;
    bit   [N-1:0]  pv = '0;
    bit   [N-1:0]  pwe = '0;
    logic [AW-1:0] pa [N];
    logic [DW-1:0] pd [N];
    bit            rd_only = 1'b0;
    int            errors = 0;
    int            checks = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // One clock cycle: optionally create new requests, drive them, then check the
    // DUT against the model: a request is accepted only when the port is free
    // (write occupies 1 cycle after accept, read 2), picking the first pending
    // requester at or after the model pointer.
    task automatic step(input bit [N-1:0] gen_mask, input int pct);
        int   w;
        int   k;
        bit   idle;
        bit   [N-1:0] exp_rdy;
        bit   e_cs, e_we, e_oe;
        exp_t e;
        for (int i = 0; i < N; i++) begin
            if (gen_mask[i] && !pv[i] && $urandom_range(99) < pct) begin
                pv[i]  = 1'b1;
                pwe[i] = rd_only ? 1'b0 : 1'($urandom_range(1));
                pa[i]  = AW'($urandom_range(15));
                pd[i]  = $urandom;
            end
        end
        @(posedge clk);
        #1;
        req_valid = pv;
        for (int i = 0; i < N; i++) begin
            req_we[i]              = pwe[i];
            req_addr[i*AW +: AW]   = pa[i];
            req_wdata[i*DW +: DW]  = pd[i];
        end
        @(negedge clk);
        idle = cyc >= free_c;
        w = -1;
        if (idle) begin
            for (int j = 0; j < N; j++) begin
                k = (ptr_m + j) % N;
                if (w < 0 && pv[k]) w = k;
            end
        end
        exp_rdy = '0;
        if (w >= 0) exp_rdy[w] = 1'b1;
        chk("req_ready", DW'(req_ready), DW'(exp_rdy));
        k = cyc - acc_c;
        e_cs = !idle;
        e_we = !idle && cur_we;
        e_oe = !idle && !cur_we && k == 2;
        chk("ram_ctl", DW'({ram_cs, ram_we, ram_oe}), DW'({e_cs, e_we, e_oe}));
        if (e_cs) chk("ram_addr", DW'(ram_addr), DW'(cur_addr));
        if (e_we) chk("ram_wdata", ram_data, cur_wdata);
        for (int j = 0; j < N; j++) if (req_valid[j] && req_ready[j]) glog.push_back(j);
        if (w >= 0) begin
            acc_c     = cyc;
            cur_we    = pwe[w];
            cur_addr  = pa[w];
            cur_wdata = pd[w];
            free_c    = cyc + (cur_we ? 2 : 3);
            if (cur_we) mem_m[cur_addr] = cur_wdata;
            else begin
                e.id   = w;
                e.data = mem_m[cur_addr];
                e.due  = cyc + 3;
                exp_q.push_back(e);
            end
            ptr_m = (w + 1) % N;
            pv[w] = 1'b0;
        end
    endtask

    task automatic drain();
        for (int t = 0; t < 60 && (pv != '0 || exp_q.size() != 0 || cyc < free_c); t++) step('0, 0);
    endtask

    task automatic set_op(input int i, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        pv[i]  = 1'b1;
        pwe[i] = w;
        pa[i]  = a;
        pd[i]  = d;
    endtask

    // Response monitor: every rsp_valid pulse must match the oldest outstanding read.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && rsp_valid != '0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected at cycle %0d: got rsp_valid %b expected none", cyc, rsp_valid);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_valid", DW'(rsp_valid), DW'(1) << e.id);
                    chk("rsp_rdata", rsp_rdata, e.data);
                    chk("rsp_latency", DW'(cyc), DW'(e.due));
                end
            end
        end
    end

    initial begin
        exp_t e;
        int   c1;
        for (int i = 0; i < 16; i++) begin
            ram[i]   = '0;
            mem_m[i] = '0;
        end
        for (int i = 0; i < N; i++) begin
            pa[i] = '0;
            pd[i] = '0;
        end
        #1 rst = 1'b1;
        req_valid = '1;
        #1;
        chk("reset_ready", DW'(req_ready), '0);
        chk("reset_rsp_valid", DW'(rsp_valid), '0);
        chk("reset_rsp_rdata", rsp_rdata, '0);
        chk("reset_ctl", DW'({ram_cs, ram_we, ram_oe}), '0);
        chk("reset_addr", DW'(ram_addr), '0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        req_valid = '0;

        // Single write then read of the same word.
        set_op(0, 1'b1, 4'd3, 32'hDEADBEEF);
        drain();
        set_op(0, 1'b0, 4'd3, '0);
        drain();

        // Reset asserted during RD_ADDR: bus released at once, no response.
        set_op(0, 1'b0, 4'd3, '0);
        step('0, 0);
        if (exp_q.size() > 0) e = exp_q.pop_back();
        @(posedge clk);
        #2;
        chk("rd_addr_cs", DW'(ram_cs), DW'(1));
        rst = 1'b1;
        #1;
        chk("midrst_ctl", DW'({ram_cs, ram_we, ram_oe}), '0);
        chk("midrst_ready", DW'(req_ready), '0);
        chk("midrst_addr", DW'(ram_addr), '0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        req_valid = '0;
        ptr_m = 0;
        free_c = 0;

        // Idle hold.
        repeat (10) step('0, 0);

        // Round-robin between requesters 0 and 1 holding reads.
        rd_only = 1'b1;
        glog.delete();
        repeat (24) step(3'b011, 100);
        chk("rr_count", DW'(glog.size() >= 6), DW'(1));
        foreach (glog[i]) chk("rr_order", DW'(glog[i]), DW'(i % 2));
        drain();

        // Move the pointer to 2, then requesters 2 and 0 only.
        set_op(1, 1'b0, 4'd7, '0);
        drain();
        glog.delete();
        repeat (24) step(3'b101, 100);
        c1 = 0;
        foreach (glog[i]) begin
            chk("wrap_order", DW'(glog[i]), (i % 2) ? DW'(0) : DW'(2));
            if (glog[i] == 1) c1++;
        end
        chk("wrap_req1_never", DW'(c1), '0);
        chk("wrap_count", DW'(glog.size() >= 6), DW'(1));
        drain();
        rd_only = 1'b0;

        // Read then write to the same address from different requesters.
        set_op(1, 1'b0, 4'd5, '0);
        for (int t = 0; t < 10 && pv[1]; t++) step('0, 0);
        set_op(0, 1'b1, 4'd5, 32'h0000_1234);
        drain();
        set_op(1, 1'b0, 4'd5, '0);
        drain();

        // Random mixed traffic.
        repeat (400) step('1, 40);
        drain();
        chk("scoreboard_empty", DW'(exp_q.size()), '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
